// File: rtl/fht_io_sched.sv
`timescale 1ns/1ps
// fht_io_sched: frame sequencer and set-A RAM-port arbiter around the FHT engine.
// Loads one frame of N = 4*2^A_BIT samples into the four set-A banks, starts the
// engine, waits for it to finish, then streams the result back out through a
// 2-entry output FIFO under a credit rule that cannot overflow.
module fht_io_sched #(
  parameter int A_BIT    = 8,
  parameter int D_BIT    = 16,
  parameter int START_TO = 4
) (
  input  logic               iCLK_2,
  input  logic               iRESET,
  input  logic               iIN_VALID,
  input  logic [D_BIT-1:0]   iIN_DATA,
  output logic               oIN_READY,
  output logic               oOUT_VALID,
  output logic [D_BIT-1:0]   oOUT_DATA,
  input  logic               iOUT_READY,
  output logic [3:0]         oBANK_WE,
  output logic               oBANK_RD,
  output logic [A_BIT-1:0]   oBANK_ADDR,
  output logic [D_BIT-1:0]   oBANK_WDATA,
  input  logic [4*D_BIT-1:0] iBANK_RDATA,
  output logic               oOWN_IO,
  output logic               oFHT_START,
  input  logic               iFHT_RDY,
  input  logic               iFLUSH,
  output logic               oBUSY,
  output logic               oFRAME_DONE,
  output logic               oERR
);

  localparam int            IW       = A_BIT + 2;
  localparam logic [IW-1:0] LAST_IDX = '1;  // N-1
  localparam int            TW       = (START_TO > 1) ? $clog2(START_TO) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_RUN, S_UNLOAD, S_DRAIN
  } state_t;

  state_t           state, state_next;
  logic [IW-1:0]    idx;           // sample index: bank = idx[1:0], address = idx[IW-1:2]
  logic [TW-1:0]    tcnt;          // cycles spent in WAIT_BUSY
  logic             err;
  logic             blk;           // engine still finishing a flushed frame
  logic             out_of_reset;  // keeps oIN_READY low while reset is asserted

  logic             rd_pend;       // read issued last cycle, data on iBANK_RDATA now
  logic [1:0]       rd_lane;
  logic [D_BIT-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt;

  logic             own_io, in_ready, accept, rd_issue, push, pop, timeout, frame_done;
  logic [1:0]       used;
  logic [D_BIT-1:0] rd_word;

  assign rd_word = iBANK_RDATA[rd_lane*D_BIT +: D_BIT];

  // Next-state logic plus the handshake, ownership and credit decisions of the current state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_next = state;
    pop        = (fifo_cnt != 2'd0) && iOUT_READY;
    push       = rd_pend;
    // Credits held after this cycle's pop: an entry leaving now frees room for a new read.
    used       = fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    in_ready   = out_of_reset && !blk && (state == S_IDLE || state == S_LOAD);
    accept     = iIN_VALID && in_ready && !iFLUSH;
    own_io     = !(state == S_START || state == S_WAIT_BUSY || (state == S_RUN && !iFHT_RDY));
    rd_issue   = (state == S_UNLOAD) && !iFLUSH && (used < 2'd2);
    frame_done = (state == S_DRAIN) && !iFLUSH && (fifo_cnt == 2'd0) && !rd_pend;
    timeout    = (state == S_WAIT_BUSY) && !iFLUSH && iFHT_RDY && (tcnt == TW'(START_TO - 1));

    unique case (state)
      S_IDLE:      if (accept) state_next = S_LOAD;
      S_LOAD:      if (accept && idx == LAST_IDX) state_next = S_START;
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!iFHT_RDY)    state_next = S_RUN;
        else if (timeout) state_next = S_IDLE;
      end
      S_RUN:       if (iFHT_RDY) state_next = S_UNLOAD;
      S_UNLOAD:    if (rd_issue && idx == LAST_IDX) state_next = S_DRAIN;
      S_DRAIN:     if (frame_done) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase

    if (iFLUSH) state_next = S_IDLE;
  end

  // FSM state register.
  always_ff @(posedge iCLK_2 or negedge iRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!iRESET) state <= S_IDLE;
    else         state <= state_next;
  end

  // Frame index, start-timeout counter, sticky error and post-flush load block.
  always_ff @(posedge iCLK_2 or negedge iRESET) begin
    if (!iRESET) begin
      idx          <= '0;
      tcnt         <= '0;
      err          <= 1'b0;
      blk          <= 1'b0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (iFLUSH)                   idx <= '0;
      else if (accept || rd_issue)  idx <= idx + IW'(1);
      tcnt <= (state == S_WAIT_BUSY) ? tcnt + TW'(1) : '0;
      if (timeout) err <= 1'b1;
      if (iFLUSH && (state == S_WAIT_BUSY || state == S_RUN)) blk <= 1'b1;
      else if (iFHT_RDY)                                      blk <= 1'b0;
    end
  end

  // Read-return tracking and output FIFO pointers/occupancy.
  always_ff @(posedge iCLK_2 or negedge iRESET) begin
    if (!iRESET) begin
      rd_pend  <= 1'b0;
      rd_lane  <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else if (iFLUSH) begin
      rd_pend  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) rd_lane <= idx[1:0];
      if (push)     wr_ptr  <= ~wr_ptr;
      if (pop)      rd_ptr  <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage: captures the selected bank lane one cycle after each read.
  always_ff @(posedge iCLK_2) begin
    // NOTE: storage is not reset; occupancy is, and the head is masked while the FIFO is empty.
    if (push) fifo_mem[wr_ptr] <= rd_word;
  end

  assign oIN_READY   = in_ready;
  assign oBANK_WE    = (accept && own_io) ? (4'b0001 << idx[1:0]) : 4'b0000;
  assign oBANK_RD    = rd_issue && own_io;
  assign oBANK_ADDR  = own_io ? idx[IW-1:2] : '0;
  assign oBANK_WDATA = accept ? iIN_DATA : '0;
  assign oOWN_IO     = own_io;
  assign oFHT_START  = (state == S_START) && !iFLUSH;
  assign oBUSY       = (state != S_IDLE);
  assign oFRAME_DONE = frame_done;
  assign oERR        = err;
  assign oOUT_VALID  = (fifo_cnt != 2'd0);
  assign oOUT_DATA   = oOUT_VALID ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fht_io_sched.sv
`timescale 1ns/1ps
// tb_fht_io_sched: randomized self-checking bench. The bench owns a model of the
// four set-A banks and a trivial engine (XOR of every word with a per-frame key),
// and predicts every write, the unload order, latencies and the control pulses.
module tb_fht_io_sched;

  localparam int A_BIT    = 8;
  localparam int D_BIT    = 16;
  localparam int START_TO = 4;
  localparam int N        = 4 << A_BIT;

  logic               iCLK_2, iRESET;
  logic               iIN_VALID, oIN_READY;
  logic [D_BIT-1:0]   iIN_DATA;
  logic               oOUT_VALID, iOUT_READY;
  logic [D_BIT-1:0]   oOUT_DATA;
  logic [3:0]         oBANK_WE;
  logic               oBANK_RD;
  logic [A_BIT-1:0]   oBANK_ADDR;
  logic [D_BIT-1:0]   oBANK_WDATA;
  logic [4*D_BIT-1:0] iBANK_RDATA;
  logic               oOWN_IO, oFHT_START, iFHT_RDY, iFLUSH;
  logic               oBUSY, oFRAME_DONE, oERR;

  fht_io_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT), .START_TO(START_TO)) dut (
    .iCLK_2(iCLK_2), .iRESET(iRESET),
    .iIN_VALID(iIN_VALID), .iIN_DATA(iIN_DATA), .oIN_READY(oIN_READY),
    .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA), .iOUT_READY(iOUT_READY),
    .oBANK_WE(oBANK_WE), .oBANK_RD(oBANK_RD), .oBANK_ADDR(oBANK_ADDR),
    .oBANK_WDATA(oBANK_WDATA), .iBANK_RDATA(iBANK_RDATA),
    .oOWN_IO(oOWN_IO), .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY),
    .iFLUSH(iFLUSH), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oERR(oERR)
  );

  initial iCLK_2 = 1'b0;
  always #5 iCLK_2 = ~iCLK_2;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bank model, engine data and protocol monitors
  logic [D_BIT-1:0]   bank_mem [4][N/4];
  logic [D_BIT-1:0]   exp_q [$];
  logic               rd_flag = 1'b0;
  logic [4*D_BIT-1:0] rd_data_nxt;
  int gate_viol = 0, onehot_viol = 0, stall_viol = 0, credit_viol = 0;
  int rd_total = 0, xfer_total = 0;
  logic prev_stall = 1'b0;
  logic [D_BIT-1:0] prev_data;

  always @(negedge iCLK_2) begin
    logic xfer;
    xfer = oOUT_VALID && iOUT_READY;
    if (!oOWN_IO && (oBANK_WE != 4'b0 || oBANK_RD)) gate_viol++;
    if ($countones(oBANK_WE) > 1) onehot_viol++;
    if (iRESET && prev_stall && (!oOUT_VALID || oOUT_DATA !== prev_data)) stall_viol++;
    if (oBANK_RD && (rd_total - xfer_total - int'(xfer)) >= 2) credit_viol++;
    for (int b = 0; b < 4; b++)
      if (oBANK_WE[b]) bank_mem[b][oBANK_ADDR] = oBANK_WDATA;
    if (oBANK_RD) begin
      rd_flag     = 1'b1;
      rd_data_nxt = {bank_mem[3][oBANK_ADDR], bank_mem[2][oBANK_ADDR],
                     bank_mem[1][oBANK_ADDR], bank_mem[0][oBANK_ADDR]};
    end
    rd_total   += int'(oBANK_RD);
    xfer_total += int'(xfer);
    if (rd_total - xfer_total > 2) credit_viol++;
    prev_stall = oOUT_VALID && !iOUT_READY && !iFLUSH;
    prev_data  = oOUT_DATA;
  end

  // Synchronous read port: data valid for exactly the cycle after the read strobe.
  always @(posedge iCLK_2) begin
    #1;
    iBANK_RDATA = rd_flag ? rd_data_nxt : 'x;
    rd_flag = 1'b0;
  end

  task automatic tick();
    @(posedge iCLK_2);
    #1;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({oIN_READY, oOUT_VALID, oOUT_DATA, oBANK_WE, oBANK_RD, oBANK_ADDR,
                oBANK_WDATA, oOWN_IO, oFHT_START, oBUSY, oFRAME_DONE, oERR});
  endfunction
  localparam logic [63:0] RESET_VEC = 64'h10;  // only oOWN_IO set

  // Streams up to n_samp samples; flush_at >= 0 aborts on that sample index.
  task automatic load_frame(input int n_samp, input int flush_at, input bit ramp, input bit gaps);
    int k = 0;
    bit stop = 1'b0;
    logic v;
    logic [D_BIT-1:0] d;
    logic [3:0] we_e;
    logic [A_BIT-1:0] addr_e;
    exp_q.delete();
    while (k < n_samp && !stop) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = ramp ? k[D_BIT-1:0] : D_BIT'($urandom);
      iIN_VALID = v;
      iIN_DATA  = d;
      iFLUSH    = v && (k == flush_at);
      @(negedge iCLK_2);
      if (iFLUSH) begin
        check("flush_write_suppressed", {oBANK_WE, oFHT_START}, 0);
        stop = 1'b1;
      end else if (v) begin
        we_e   = 4'b0001 << (k % 4);
        addr_e = A_BIT'(k / 4);
        check($sformatf("load_write[%0d]", k), {oIN_READY, oBANK_WE, oBANK_ADDR, oBANK_WDATA},
              {1'b1, we_e, addr_e, d});
        exp_q.push_back(d);
        k++;
      end else begin
        check("load_gap_no_write", oBANK_WE, 0);
      end
      tick();
    end
    iIN_VALID = 1'b0;
    iFLUSH    = 1'b0;
    if (stop) begin
      @(negedge iCLK_2);
      check("flush_to_idle", {oBUSY, oFHT_START, oOWN_IO}, 3'b001);
      tick();
    end
  endtask

  // Current cycle must be START; leaves the engine busy in the first RUN cycle.
  task automatic start_wait();
    @(negedge iCLK_2);
    check("start_pulse", {oFHT_START, oOWN_IO, oIN_READY, oBUSY}, 4'b1001);
    tick();
    iFHT_RDY = 1'b0;
    @(negedge iCLK_2);
    check("start_single", {oFHT_START, oOWN_IO}, 2'b00);
    tick();
  endtask

  // Engine works for run_len cycles, then reports ready; leaves at UNLOAD entry.
  task automatic run_finish(input int run_len);
    logic [D_BIT-1:0] key;
    key = D_BIT'($urandom);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < N/4; a++) bank_mem[b][a] = bank_mem[b][a] ^ key;
    foreach (exp_q[i]) exp_q[i] = exp_q[i] ^ key;
    repeat (run_len) tick();
    @(negedge iCLK_2);
    check("run_state", {oOWN_IO, oBUSY, oIN_READY}, 3'b010);
    tick();
    iFHT_RDY = 1'b1;
    @(negedge iCLK_2);
    check("run_release_own", oOWN_IO, 1'b1);
    tick();
  endtask

  task automatic unload(input bit rand_ready);
    int c = 0, first_v = -1, last_x = -1, done_c = -1, done_n = 0;
    logic [D_BIT-1:0] got [$];
    rd_total   = 0;
    xfer_total = 0;
    while (c < 6*N && done_c < 0) begin
      iOUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge iCLK_2);
      if (oOUT_VALID && first_v < 0) first_v = c;
      if (oOUT_VALID && iOUT_READY) begin
        got.push_back(oOUT_DATA);
        last_x = c;
      end
      if (oFRAME_DONE) begin
        done_n++;
        done_c = c;
      end
      tick();
      c++;
    end
    iOUT_READY = 1'b1;
    @(negedge iCLK_2);
    check("unload_idle_after", {oBUSY, oOWN_IO, oOUT_VALID}, 3'b010);
    repeat (3) begin
      if (oFRAME_DONE) done_n++;
      tick();
      @(negedge iCLK_2);
    end
    tick();
    check("unload_count", got.size(), N);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("unload_data[%0d]", i), got[i], exp_q[i]);
    check("unload_first_valid", first_v, 2);
    check("frame_done_pulses", done_n, 1);
    check("frame_done_timing", done_c, last_x + 1);
    check("unload_reads", rd_total, N);
    if (!rand_ready) check("unload_last_xfer", last_x, N + 1);
  endtask

  initial begin
    int c;
    bit found;
    iRESET = 1'b0; iIN_VALID = 1'b0; iIN_DATA = '0; iOUT_READY = 1'b1;
    iFHT_RDY = 1'b1; iFLUSH = 1'b0; iBANK_RDATA = 'x;

    // Reset values
    repeat (3) @(negedge iCLK_2);
    check("reset_values", out_vec(), RESET_VEC);
    iRESET = 1'b1;
    tick();
    @(negedge iCLK_2);
    check("idle_after_reset", {oIN_READY, oOWN_IO, oBUSY, oERR}, 4'b1100);
    tick();

    // Ramp load, long engine run, unload at full rate
    load_frame(N, -1, 1'b1, 1'b0);
    start_wait();
    run_finish(2600);
    unload(1'b0);

    // Random data with input gaps, random output backpressure
    load_frame(N, -1, 1'b0, 1'b1);
    start_wait();
    run_finish(37);
    unload(1'b1);

    // Engine never leaves ready: start timeout
    load_frame(N, -1, 1'b0, 1'b0);
    @(negedge iCLK_2);
    check("timeout_start", oFHT_START, 1'b1);
    c = 0;
    found = 1'b0;
    while (c < START_TO + 10 && !found) begin
      tick();
      c++;
      @(negedge iCLK_2);
      if (oERR) found = 1'b1;
    end
    check("err_latency", c, START_TO + 1);
    check("err_state", {oERR, oBUSY, oOWN_IO, oIN_READY}, 4'b1011);
    tick();

    // Flush while the engine runs: loading blocked until it reports ready
    load_frame(N, -1, 1'b0, 1'b0);
    start_wait();
    repeat (5) tick();
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    @(negedge iCLK_2);
    check("flush_run_idle", {oBUSY, oIN_READY, oOWN_IO}, 3'b001);
    repeat (5) tick();
    @(negedge iCLK_2);
    check("flush_run_blocked", oIN_READY, 1'b0);
    tick();
    iFHT_RDY = 1'b1;
    tick();
    @(negedge iCLK_2);
    check("flush_run_unblocked", oIN_READY, 1'b1);
    tick();

    // Flush mid-load, then a complete new frame
    load_frame(N, 500, 1'b0, 1'b1);
    load_frame(N, -1, 1'b0, 1'b1);
    start_wait();
    run_finish(60);
    unload(1'b1);

    // Flush coinciding with the last load accept
    load_frame(N, N - 1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN
    load_frame(N, -1, 1'b0, 1'b0);
    start_wait();
    repeat (10) tick();
    iIN_VALID = 1'b1;
    iIN_DATA  = '1;
    iRESET    = 1'b0;
    #1;
    check("reset_mid_run", out_vec(), RESET_VEC);
    @(negedge iCLK_2);
    check("reset_mid_run_hold", out_vec(), RESET_VEC);
    iIN_VALID = 1'b0;
    iFHT_RDY  = 1'b1;
    iRESET    = 1'b1;
    tick();
    @(negedge iCLK_2);
    check("after_mid_reset", {oIN_READY, oERR, oBUSY, oOWN_IO}, 4'b1001);
    tick();

    check("own_gating_violations", gate_viol, 0);
    check("we_onehot_violations", onehot_viol, 0);
    check("stall_stability_violations", stall_viol, 0);
    check("credit_violations", credit_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
